rib_rr: RTL and testbench

- Parametrised successor to the fixed 4-master/6-slave system bus.
- N masters share M slaves through a registered round-robin arbiter. The grant is locked for the whole transaction, and completion uses a slave-ack handshake, so slaves may take multiple cycles.
- Sits between the core's fetch/LSU/debug/DMA ports and the RAM, ROM, timer, UART, GPIO and SPI slaves.
- Unmapped addresses return an error response instead of silently reading zero.

---
 rtl/rib_pkg.sv | 24 ++
 rtl/rib_rr_arbiter.sv | 46 ++++
 rtl/rib_rr.sv | 190 +++++++++++++++++++
 tb/tb_rib_rr.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_pkg.sv
// rib_pkg: shared definitions for the rib_rr system bus.
//   state_t   - transaction FSM states (IDLE/BUSY/RESP)
//   REGION_W  - number of top address bits that select a slave region
//   SIZE_*    - access size encodings carried on m_size_i / s_size_o
//   idx_w()   - index width for a vector of n entries (minimum 1 bit)
package rib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned REGION_W = 4;

    localparam logic [2:0] SIZE_B = 3'b000;
    localparam logic [2:0] SIZE_H = 3'b001;
    localparam logic [2:0] SIZE_W = 3'b010;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rib_rr_arbiter.sv
// rib_rr_arbiter: combinational rotate-priority encoder.
// Picks the first set bit of req at or after ptr, scanning upward and wrapping.
//   req    in  N          request vector
//   ptr    in  idx_w(N)   round-robin start position
//   winner out idx_w(N)   granted index (meaningful only when valid)
//   valid  out 1          at least one request present
module rib_rr_arbiter
    import rib_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [idx_w(N)-1:0]   winner,
    output logic                  valid
);

    localparam int unsigned IW = idx_w(N);
    localparam logic [IW:0] NN = (IW+1)'(N);

    logic [2*N-1:0] rot2;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Rotate so bit 0 is the pointer position, find the first set bit,
    // then add the offset back modulo N.
    always_comb begin
        rot2   = {req, req} >> ptr;
        rot    = rot2[N-1:0];
        valid  = 1'b0;
        off    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid && rot[i]) begin
                valid = 1'b1;
                off   = IW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NN) begin
            sum = sum - NN;
        end
        winner = sum[IW-1:0];
    end

endmodule

// File: rtl/rib_rr.sv
// rib_rr: N-master / M-slave system bus with registered round-robin arbiter.
// Grant is locked for the whole transaction; slaves complete with s_ack_i.
// Optional macro RIB_TIMEOUT_EN adds a BUSY-state watchdog (TIMEOUT_CYCLES).
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   m_req_i/m_we_i/m_addr_i/m_wdata_i/m_size_i   master request side
//   m_rdata_o/m_ack_o/m_err_o                    master response side
//   s_sel_o/s_addr_o/s_wdata_o/s_we_o/s_re_o/s_size_o  slave strobes
//   s_rdata_i/s_ack_i                            slave response
//   hold_flag_o     some master other than the current owner is waiting
module rib_rr
    import rib_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned NUM_SLAVES     = 6,
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS-1:0]      m_req_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_wdata_i,
    input  logic [NUM_MASTERS*3-1:0]    m_size_i,
    output logic [NUM_MASTERS*DW-1:0]   m_rdata_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_SLAVES-1:0]       s_sel_o,
    output logic [AW-1:0]               s_addr_o,
    output logic [DW-1:0]               s_wdata_o,
    output logic                        s_we_o,
    output logic                        s_re_o,
    output logic [2:0]                  s_size_o,
    input  logic [NUM_SLAVES*DW-1:0]    s_rdata_i,
    input  logic [NUM_SLAVES-1:0]       s_ack_i,
    output logic                        hold_flag_o
);

    localparam int unsigned       IW   = idx_w(NUM_MASTERS);
    localparam logic [REGION_W:0] NS   = (REGION_W+1)'(NUM_SLAVES);
    localparam logic [IW-1:0]     LAST = IW'(NUM_MASTERS-1);

    state_t                 state;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          owner;
    logic [IW-1:0]          win;
    logic                   win_valid;
    logic [AW-1:0]          win_addr;
    logic [DW-1:0]          win_wdata;
    logic [2:0]             win_size;
    logic                   win_we;
    logic [REGION_W-1:0]    win_region;
    logic                   decode_ok;
    logic [NUM_MASTERS-1:0] win_bit;
    logic [NUM_MASTERS-1:0] owner_bit;
    logic [NUM_MASTERS-1:0] owner_onehot;
    logic [DW-1:0]          slave_rdata;
    logic                   ack_hit;

`ifdef RIB_TIMEOUT_EN
    localparam int unsigned TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TW = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] cnt;
`endif

    rib_rr_arbiter #(
        .N (NUM_MASTERS)
    ) u_arb (
        .req    (m_req_i),
        .ptr    (ptr),
        .winner (win),
        .valid  (win_valid)
    );

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_size  = '0;
        win_we    = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (IW'(i) == win) begin
                win_addr  = m_addr_i[i*AW +: AW];
                win_wdata = m_wdata_i[i*DW +: DW];
                win_size  = m_size_i[i*3 +: 3];
                win_we    = m_we_i[i];
            end
        end
        win_region = win_addr[AW-1 -: REGION_W];
        decode_ok  = ({1'b0, win_region} < NS);
        win_bit    = NUM_MASTERS'(1) << win;
        owner_bit  = NUM_MASTERS'(1) << owner;
    end

    // s_sel_o is the registered one-hot select, so it doubles as the ack mask
    // and the read-data mux select while BUSY.
    always_comb begin
        slave_rdata = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (s_sel_o[k]) begin
                slave_rdata = s_rdata_i[k*DW +: DW];
            end
        end
        ack_hit = |(s_ack_i & s_sel_o);
    end

    assign owner_onehot = (state == IDLE) ? '0 : owner_bit;
    assign hold_flag_o  = |(m_req_i & ~owner_onehot);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            m_rdata_o <= '0;
            m_ack_o   <= '0;
            m_err_o   <= '0;
            s_sel_o   <= '0;
            s_addr_o  <= '0;
            s_wdata_o <= '0;
            s_we_o    <= 1'b0;
            s_re_o    <= 1'b0;
            s_size_o  <= '0;
`ifdef RIB_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            m_ack_o <= '0;
            m_err_o <= '0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        owner <= win;
                        if (decode_ok) begin
                            state     <= BUSY;
                            s_sel_o   <= NUM_SLAVES'(1) << win_region;
                            s_addr_o  <= {{REGION_W{1'b0}}, win_addr[AW-REGION_W-1:0]};
                            s_wdata_o <= win_wdata;
                            s_size_o  <= win_size;
                            s_we_o    <= win_we;
                            s_re_o    <= ~win_we;
`ifdef RIB_TIMEOUT_EN
                            cnt       <= '0;
`endif
                        end else begin
                            // Unmapped region: answer with an error directly.
                            state     <= RESP;
                            m_ack_o   <= win_bit;
                            m_err_o   <= win_bit;
                            m_rdata_o <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (ack_hit) begin
                        state     <= RESP;
                        s_sel_o   <= '0;
                        s_we_o    <= 1'b0;
                        s_re_o    <= 1'b0;
                        m_ack_o   <= owner_bit;
                        m_rdata_o <= {NUM_MASTERS{slave_rdata}};
                    end
`ifdef RIB_TIMEOUT_EN
                    else if (cnt == LIMIT) begin
                        state     <= RESP;
                        s_sel_o   <= '0;
                        s_we_o    <= 1'b0;
                        s_re_o    <= 1'b0;
                        m_ack_o   <= owner_bit;
                        m_err_o   <= owner_bit;
                        m_rdata_o <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    ptr   <= (owner == LAST) ? '0 : owner + 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rib_rr.sv
// tb_rib_rr: directed self-checking bench for rib_rr (4 masters, 6 slaves).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_rib_rr;
    import rib_pkg::*;

    localparam int unsigned NM = 4;
    localparam int unsigned NS = 6;

    logic            clk;
    logic            rst;
    logic [NM-1:0]   m_req;
    logic [NM-1:0]   m_we;
    logic [NM*32-1:0] m_addr;
    logic [NM*32-1:0] m_wdata;
    logic [NM*3-1:0] m_size;
    logic [NM*32-1:0] m_rdata;
    logic [NM-1:0]   m_ack;
    logic [NM-1:0]   m_err;
    logic [NS-1:0]   s_sel;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic            s_we;
    logic            s_re;
    logic [2:0]      s_size;
    logic [NS*32-1:0] s_rdata;
    logic [NS-1:0]   s_ack;
    logic            hold_flag;

    logic            auto_ack;
    logic [NS-1:0]   manual_ack;

    int vectors = 0;
    int miscompares = 0;

    // Slave model: either ack whatever is selected immediately, or follow manual_ack.
    assign s_ack = auto_ack ? s_sel : manual_ack;

    rib_rr #(
        .NUM_MASTERS    (NM),
        .NUM_SLAVES     (NS),
        .AW             (32),
        .DW             (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req_i     (m_req),
        .m_we_i      (m_we),
        .m_addr_i    (m_addr),
        .m_wdata_i   (m_wdata),
        .m_size_i    (m_size),
        .m_rdata_o   (m_rdata),
        .m_ack_o     (m_ack),
        .m_err_o     (m_err),
        .s_sel_o     (s_sel),
        .s_addr_o    (s_addr),
        .s_wdata_o   (s_wdata),
        .s_we_o      (s_we),
        .s_re_o      (s_re),
        .s_size_o    (s_size),
        .s_rdata_i   (s_rdata),
        .s_ack_i     (s_ack),
        .hold_flag_o (hold_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b0;
        m_req      = '1;
        m_we       = '0;
        m_addr     = '0;
        m_wdata    = '0;
        m_size     = '0;
        auto_ack   = 1'b1;
        manual_ack = '0;
        for (int k = 0; k < NS; k++) s_rdata[k*32 +: 32] = 32'h5A00_0000 + k;
        s_rdata[3*32 +: 32] = 32'hDEAD_BEEF;
        for (int i = 0; i < NM; i++) begin
            m_addr[i*32 +: 32] = 32'h1000_0000 + i * 16;
            m_size[i*3 +: 3]   = SIZE_W;
        end

        // Reset held for two edges with every master requesting.
        @(negedge clk);
        @(negedge clk);
        check("rst_sel",   64'(s_sel),   64'h0);
        check("rst_we",    64'(s_we),    64'h0);
        check("rst_re",    64'(s_re),    64'h0);
        check("rst_ack",   64'(m_ack),   64'h0);
        check("rst_err",   64'(m_err),   64'h0);
        check("rst_rdata", 64'(|m_rdata), 64'h0);
        check("rst_addr",  64'(s_addr),  64'h0);
        check("rst_wdata", 64'(s_wdata), 64'h0);
        check("rst_size",  64'(s_size),  64'h0);
        rst = 1'b1;

        // Round-robin: grants 0,1,2,3,0, one ack every 3 cycles, hold asserted.
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            check("rr_sel",  64'(s_sel),  64'b000010);
            check("rr_addr", 64'(s_addr), 64'((g % 4) * 16));
            check("rr_re",   64'(s_re),   64'h1);
            check("rr_hold", 64'(hold_flag), 64'h1);
            @(negedge clk);
            check("rr_ack",   64'(m_ack), 64'(1 << (g % 4)));
            check("rr_err",   64'(m_err), 64'h0);
            check("rr_rdata", 64'(m_rdata[(g % 4)*32 +: 32]), 64'h5A00_0001);
            check("rr_hold2", 64'(hold_flag), 64'h1);
            @(negedge clk);
            check("rr_gap", 64'(m_ack), 64'h0);
            check("rr_hold3", 64'(hold_flag), 64'h1);
        end
        m_req = '0;

        // Single read from m1 to UART; slave acks in the 4th BUSY cycle.
        auto_ack = 1'b0;
        m_req = 4'b0010;
        m_addr[1*32 +: 32] = 32'h3000_0010;
        @(negedge clk);
        check("rd_sel",  64'(s_sel),  64'b001000);
        check("rd_addr", 64'(s_addr), 64'h0000_0010);
        check("rd_re",   64'(s_re),   64'h1);
        check("rd_we",   64'(s_we),   64'h0);
        check("rd_size", 64'(s_size), 64'(SIZE_W));
        check("rd_ack0", 64'(m_ack),  64'h0);
        m_req = '0;                 // dropping the request must not abort
        manual_ack = 6'b000100;     // unselected slave ack is ignored
        @(negedge clk);
        check("rd_hold_drop", 64'(hold_flag), 64'h0);
        check("rd_sel2", 64'(s_sel), 64'b001000);
        @(negedge clk);
        check("rd_ign", 64'(m_ack), 64'h0);
        manual_ack = '0;
        @(negedge clk);
        check("rd_sel4", 64'(s_sel), 64'b001000);
        manual_ack = 6'b001000;
        @(negedge clk);
        manual_ack = '0;
        check("rd_ack",   64'(m_ack), 64'b0010);
        check("rd_err",   64'(m_err), 64'h0);
        check("rd_rdata", 64'(m_rdata[1*32 +: 32]), 64'hDEAD_BEEF);
        check("rd_desel", 64'(s_sel), 64'h0);
        @(negedge clk);
        check("rd_pulse", 64'(m_ack), 64'h0);

        // Decode error: m2 writes to region 0xF.
        m_req = 4'b0100;
        m_we[2] = 1'b1;
        m_addr[2*32 +: 32]  = 32'hF000_0000;
        m_wdata[2*32 +: 32] = 32'hCAFE_0002;
        @(negedge clk);
        m_req = '0;
        check("de_sel",   64'(s_sel), 64'h0);
        check("de_we",    64'(s_we),  64'h0);
        check("de_ack",   64'(m_ack), 64'b0100);
        check("de_err",   64'(m_err), 64'b0100);
        check("de_rdata", 64'(|m_rdata), 64'h0);
        @(negedge clk);
        check("de_pulse", 64'(m_ack), 64'h0);

        // Reset mid-transaction: m0 byte write to RAM, slave never acks.
        m_req = 4'b0001;
        m_we[0] = 1'b1;
        m_addr[0*32 +: 32]  = 32'h0000_0040;
        m_wdata[0*32 +: 32] = 32'h1234_5678;
        m_size[0*3 +: 3]    = SIZE_B;
        @(negedge clk);
        check("mr_sel",   64'(s_sel),   64'b000001);
        check("mr_we",    64'(s_we),    64'h1);
        check("mr_re",    64'(s_re),    64'h0);
        check("mr_wdata", 64'(s_wdata), 64'h1234_5678);
        check("mr_size",  64'(s_size),  64'(SIZE_B));
        check("mr_addr",  64'(s_addr),  64'h40);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mr_sel_rst", 64'(s_sel), 64'h0);
        check("mr_we_rst",  64'(s_we),  64'h0);
        check("mr_ack_rst", 64'(m_ack), 64'h0);
        rst = 1'b1;
        m_req = '0;
        @(negedge clk);
        check("mr_noack", 64'(m_ack), 64'h0);

        // Pointer restarts at 0 after reset: m1 wins over m3, then m3.
        auto_ack = 1'b1;
        m_req = 4'b1010;
        m_we  = '0;
        m_addr[1*32 +: 32] = 32'h2000_0008;
        m_addr[3*32 +: 32] = 32'h4000_000C;
        @(negedge clk);
        check("pr_sel1",  64'(s_sel),  64'b000100);
        check("pr_addr1", 64'(s_addr), 64'h8);
        check("pr_noack", 64'(m_ack),  64'h0);
        @(negedge clk);
        check("pr_ack1",   64'(m_ack), 64'b0010);
        check("pr_rdata1", 64'(m_rdata[1*32 +: 32]), 64'h5A00_0002);
        m_req = 4'b1000;
        @(negedge clk);
        check("pr_gap", 64'(m_ack), 64'h0);
        @(negedge clk);
        check("pr_sel3",  64'(s_sel),  64'b010000);
        check("pr_addr3", 64'(s_addr), 64'hC);
        @(negedge clk);
        check("pr_ack3",   64'(m_ack), 64'b1000);
        check("pr_rdata3", 64'(m_rdata[3*32 +: 32]), 64'h5A00_0004);
        m_req = '0;
        @(negedge clk);
        check("pr_idle", 64'(m_ack), 64'h0);

`ifdef RIB_TIMEOUT_EN
        // Timeout: m0 reads RAM, no ack; error after exactly 8 BUSY cycles.
        auto_ack = 1'b0;
        m_req = 4'b0001;
        m_addr[0*32 +: 32] = 32'h0000_0000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("to_busy_sel", 64'(s_sel), 64'b000001);
            check("to_busy_ack", 64'(m_ack), 64'h0);
        end
        @(negedge clk);
        m_req = '0;
        check("to_ack",   64'(m_ack), 64'b0001);
        check("to_err",   64'(m_err), 64'b0001);
        check("to_rdata", 64'(|m_rdata), 64'h0);
        check("to_desel", 64'(s_sel), 64'h0);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
